// File: rtl/if_fetch_stage.sv
// Instruction fetch: owns fetch PC, one-outstanding imem requests, 2-entry buffer.
// Ports: redirect_*, id_ready in; imem_req/addr/gnt/rvalid/rdata bus; pc/instr/valid to IF/ID.
module if_fetch_stage #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned INST_LEN   = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h8000_0000,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                redirect_valid,
  input  logic [XLEN-1:0]     redirect_pc,
  input  logic                id_ready,
  output logic                imem_req,
  output logic [XLEN-1:0]     imem_addr,
  input  logic                imem_gnt,
  input  logic                imem_rvalid,
  input  logic [INST_LEN-1:0] imem_rdata,
  output logic [XLEN-1:0]     pc_if_o,
  output logic [INST_LEN-1:0] instr_if_o,
  output logic                if_valid_o
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_DROP
  } state_t;

  state_t              r_state;
  logic                r_imem_req;
  logic [XLEN-1:0]     r_fetch_pc;
  logic [XLEN-1:0]     r_req_pc;
  logic [XLEN-1:0]     r_pc_q  [FIFO_DEPTH];
  logic [INST_LEN-1:0] r_ins_q [FIFO_DEPTH];
  logic [AW-1:0]       r_rd_ptr;
  logic [AW-1:0]       r_wr_ptr;
  logic [CW-1:0]       r_count;

  logic                w_valid;
  logic                w_pop;
  logic                w_push;
  logic [CW-1:0]       w_count_nxt;
  logic                w_credit;

  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid & id_ready;
  assign w_push  = (r_state == S_WAIT) & imem_rvalid & ~redirect_valid;

  assign w_count_nxt = r_count + CW'(w_push) - CW'(w_pop);
  // Room for one more response after this cycle's push/pop.
  assign w_credit    = (w_count_nxt < CW'(FIFO_DEPTH));

  assign imem_req   = r_imem_req;
  assign imem_addr  = r_fetch_pc;
  assign if_valid_o = w_valid;
  assign pc_if_o    = w_valid ? r_pc_q[r_rd_ptr]  : '0;
  assign instr_if_o = w_valid ? r_ins_q[r_rd_ptr] : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_imem_req <= 1'b0;
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= '0;
    end else if (redirect_valid) begin
      r_fetch_pc <= redirect_pc & ~XLEN'(3);
      unique case (r_state)
        S_IDLE: begin
          r_state    <= S_REQ;
          r_imem_req <= 1'b1;
        end
        S_REQ: begin
          // A granted request is already in flight: its reply must be eaten.
          r_state    <= imem_gnt ? S_DROP : S_REQ;
          r_imem_req <= ~imem_gnt;
        end
        S_WAIT, S_DROP: begin
          r_state    <= imem_rvalid ? S_REQ : S_DROP;
          r_imem_req <= imem_rvalid;
        end
      endcase
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_credit) begin
            r_state    <= S_REQ;
            r_imem_req <= 1'b1;
          end
        end
        S_REQ: begin
          if (imem_gnt) begin
            r_state    <= S_WAIT;
            r_imem_req <= 1'b0;
            r_req_pc   <= r_fetch_pc;
            r_fetch_pc <= r_fetch_pc + XLEN'(4);
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            r_state    <= w_credit ? S_REQ : S_IDLE;
            r_imem_req <= w_credit;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            r_state    <= S_IDLE;
            r_imem_req <= 1'b0;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (redirect_valid) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= w_count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_pc_q[r_wr_ptr]  <= r_req_pc;
      r_ins_q[r_wr_ptr] <= imem_rdata;
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Randomized bench for if_fetch_stage with a fetch-order scoreboard.
// Memory model grants/answers randomly; monitor compares pops and request addresses.
module tb_if_fetch_stage;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        id_ready = 1'b0;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [63:0] pc_if_o;
  logic [31:0] instr_if_o;
  logic        if_valid_o;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  if_fetch_stage dut (
    .clk(clk),
    .rst_n(rst_n),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .id_ready(id_ready),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata),
    .pc_if_o(pc_if_o),
    .instr_if_o(instr_if_o),
    .if_valid_o(if_valid_o)
  );

  function automatic logic [31:0] mem_f(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h1357_9bdf;
  endfunction

  // memory model state
  bit          pend = 0;
  logic [63:0] pend_addr = '0;
  int          lat = 0;
  int          gnt_pct = 100;
  int          min_lat = 0;
  int          max_lat = 0;

  // reference model: addresses fetched and not yet consumed, next fetch address
  logic [63:0] exp_q[$];
  logic [63:0] exp_req = RPC;
  int          n_pops = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    redirect_valid = 1'b0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    if (pend) begin
      if (lat == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata = mem_f(pend_addr);
        pend = 0;
      end else begin
        lat--;
      end
    end
    if (imem_req && !pend && ($urandom_range(0, 99) < gnt_pct)) begin
      imem_gnt = 1'b1;
      pend = 1;
      pend_addr = imem_addr;
      lat = $urandom_range(min_lat, max_lat);
    end
  endtask

  task automatic wait_sig(input int which, input string name);
    bit hit;
    for (int n = 0; n < 50; n++) begin
      tick();
      hit = (which == 0) ? imem_req : (which == 1) ? imem_gnt : imem_rvalid;
      if (hit) return;
    end
    checks++;
    errors++;
    $display("FAIL %s: no event in 50 cycles, expected one", name);
  endtask

  // monitor / scoreboard
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        exp_q.delete();
        exp_req = RPC;
      end else begin
        if (!if_valid_o) begin
          chk("bubble pc", pc_if_o, '0);
          chk("bubble instr", {32'b0, instr_if_o}, '0);
        end
        if (if_valid_o && id_ready) begin
          n_pops++;
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL spurious pop: got pc %h expected no entry", pc_if_o);
          end else begin
            e = exp_q.pop_front();
            chk("pop pc", pc_if_o, e);
            chk("pop instr", {32'b0, instr_if_o}, {32'b0, mem_f(e)});
          end
        end
        if (imem_req) chk("req addr", imem_addr, exp_req);
        if (redirect_valid) begin
          exp_q.delete();
          exp_req = {redirect_pc[63:2], 2'b00};
        end else if (imem_req && imem_gnt) begin
          exp_q.push_back(exp_req);
          exp_req = exp_req + 64'd4;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    // reset state
    id_ready = 1'b1;
    repeat (3) tick();
    chk("rst req", imem_req, 0);
    chk("rst valid", if_valid_o, 0);
    chk("rst pc", pc_if_o, 0);
    chk("rst instr", {32'b0, instr_if_o}, 0);
    rst_n = 1'b1;

    // streaming with a 1-cycle memory
    n_pops = 0;
    wait_sig(0, "first req");
    chk("first addr", imem_addr, RPC);
    repeat (8) tick();
    chk("stream pops", n_pops >= 3, 1);

    // stall from reset: buffer fills to two entries, then requests stop
    tick();
    rst_n = 1'b0;
    id_ready = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("stall no req", imem_req, 0);
    end
    chk("stall valid", if_valid_o, 1);
    chk("stall head", pc_if_o, RPC);
    chk("stall depth", exp_q.size(), 2);
    n_pops = 0;
    id_ready = 1'b1;
    repeat (6) tick();
    chk("drain pops", n_pops >= 2, 1);

    // redirect in the grant cycle
    wait_sig(1, "gnt for redirect");
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0100;
    wait_sig(0, "req after drop");
    chk("drop target", imem_addr, 64'h8000_0100);
    repeat (6) tick();

    // redirect with a full buffer, unaligned target
    id_ready = 1'b0;
    repeat (10) tick();
    chk("full valid", if_valid_o, 1);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0203;
    tick();
    chk("flush valid", if_valid_o, 0);
    chk("flush req", imem_req, 1);
    chk("flush addr", imem_addr, 64'h8000_0200);
    id_ready = 1'b1;
    repeat (6) tick();

    // redirect coinciding with a response in WAIT
    max_lat = 1;
    wait_sig(2, "rvalid for redirect");
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0400;
    tick();
    chk("rv redir req", imem_req, 1);
    chk("rv redir addr", imem_addr, 64'h8000_0400);
    repeat (6) tick();

    // reset during WAIT with a late response
    min_lat = 3;
    max_lat = 3;
    wait_sig(1, "gnt before reset");
    tick();
    rst_n = 1'b0;
    #1;
    chk("mid rst req", imem_req, 0);
    chk("mid rst valid", if_valid_o, 0);
    chk("mid rst pc", pc_if_o, 0);
    chk("mid rst instr", {32'b0, instr_if_o}, 0);
    tick();
    rst_n = 1'b1;
    min_lat = 0;
    max_lat = 1;
    wait_sig(0, "req after reset");
    chk("restart addr", imem_addr, RPC);
    n_pops = 0;
    repeat (12) tick();
    chk("restart pops", n_pops > 0, 1);

    // randomized traffic
    gnt_pct = 70;
    max_lat = 3;
    n_pops = 0;
    for (int i = 0; i < 3000; i++) begin
      tick();
      id_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 99) < 3) begin
        redirect_valid = 1'b1;
        if ($urandom_range(0, 3) == 0)
          redirect_pc = 64'hFFFF_FFFF_FFFF_FFF0 + 64'($urandom_range(0, 15));
        else
          redirect_pc = {$urandom(), $urandom()};
      end
    end
    chk("random pops", n_pops > 100, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
Instruction-fetch stage of the pipelined core. It sits directly upstream of the IF/ID register and feeds it {pc, instr}. It owns the fetch PC and issues one request at a time on the instruction-memory request/response bus. Fetched instructions are held in a small FIFO so that memory latency is decoupled from ID stalls. Branch/trap redirects flush the FIFO, retarget the PC and discard any in-flight response.

Parameters:
XLEN, 64, width of PC and memory address
INST_LEN, 32, instruction width
RESET_PC, 64'h8000_0000, first fetch address after reset
FIFO_DEPTH, 2, instruction buffer entries (power of 2, >=2)

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
redirect_valid  input  1  branch/jump/trap redirect from EX/CSR this cycle
redirect_pc  input  XLEN  redirect target
id_ready  input  1  IF/ID register accepts this cycle (stall_n & ~in_trap_id & ~out_trap_id, built outside)
imem_req  output  1  fetch request valid
imem_addr  output  XLEN  fetch address, bits [1:0] always 0
imem_gnt  input  1  memory accepts request this cycle
imem_rvalid  input  1  response valid
imem_rdata  input  INST_LEN  response instruction
pc_if_o  output  XLEN  PC of FIFO head
instr_if_o  output  INST_LEN  instruction at FIFO head
if_valid_o  output  1  FIFO non-empty

Behaviour:
- Reset (async, rst_n=0): fetch_pc=RESET_PC, state=IDLE, FIFO count=0, imem_req=0, if_valid_o=0, pc_if_o=0, instr_if_o=0.
- Output: when FIFO empty, pc_if_o=0 and instr_if_o=0 (bubble = all-zero, same as ID flush convention). Otherwise both show the head entry.
- Pop: head pops when if_valid_o & id_ready. The consumer sees the next entry (or zeros) the following cycle.
- Credit: a request may start only if count + outstanding < FIFO_DEPTH, so a response can never find the FIFO full.
- States:
  - IDLE: imem_req=0. Go to REQ when credit is available and there is no redirect this cycle.
  - REQ: imem_req=1, imem_addr=fetch_pc. On imem_gnt, go to WAIT, latch req_pc=fetch_pc, and set fetch_pc+=4.
  - WAIT: imem_req=0. On imem_rvalid, push {req_pc, imem_rdata}. Next state is REQ if credit remains after the push, else IDLE. A same-cycle pop counts toward credit.
  - DROP: wait for the rvalid of a discarded request, push nothing, then go to IDLE.
- Latency: at most one outstanding request. With a 1-cycle-response memory, throughput is one instruction per 2 cycles. Latency from imem_rvalid to if_valid_o is 1 cycle (registered FIFO).
- Redirect (highest priority, any state):
  - FIFO is cleared (count=0, if_valid_o=0 next cycle) and fetch_pc = {redirect_pc[XLEN-1:2], 2'b00}.
  - IDLE, or REQ without gnt: next state is REQ with the new address. The ungranted request is retargeted; no stale request remains.
  - REQ with same-cycle gnt, or WAIT without rvalid: go to DROP; that response is discarded. Do not advance fetch_pc by 4.
  - WAIT with same-cycle rvalid: the response is dropped (not pushed); next state REQ.
  - DROP: stay DROP with the new fetch_pc; a same-cycle rvalid goes to REQ.
  - A pop in the redirect cycle is still consumed by ID; the ID side flushes it on its own.
- Simultaneous push and pop with count==FIFO_DEPTH: impossible by credit. Push and pop on non-empty keep count unchanged.
- Wrap-around: fetch_pc+4 wraps modulo 2^XLEN; FIFO pointers wrap modulo FIFO_DEPTH.
- Reset asserted mid-request: all state clears immediately. Responses arriving after reset release while in IDLE/REQ are ignored.
- Only 32-bit aligned instructions are supported (no RVC).

Test Plan:
- Reset release, 1-cycle memory returning addr-derived data, id_ready=1 -> first request at 0x8000_0000. if_valid_o then shows pc 0x8000_0000, 0x8000_0004, 0x8000_0008 in order with matching data.
- id_ready=0 for 10 cycles -> exactly 2 entries buffered (0x8000_0000, 0x8000_0004), imem_req stays 0. On id_ready=1 both drain in order with no loss or duplication.
- Redirect to 0x8000_0100 in the same cycle as imem_gnt -> state DROP, stale response not pushed. Next request addr 0x8000_0100 and its pc/instr appear at the output.
- Redirect to 0x8000_0203 with FIFO holding 2 entries -> if_valid_o=0 next cycle, next imem_addr=0x8000_0200.
- Redirect coinciding with imem_rvalid in WAIT -> response dropped, next cycle imem_req=1 at the redirect target.
- rst_n pulsed low during WAIT -> outputs immediately zero. After release, fetch restarts at 0x8000_0000 and a late rvalid is ignored.
